loader_fsm: RTL and testbench

LOADER_FSM -- requirements
Module: loader_fsm

---
 rtl/loader_fsm.sv | 110 +++++++++++
 tb/tb_loader_fsm.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/loader_fsm.sv
// Byte-stream program loader: packs byte pairs into 16-bit words and writes them
// to RAM from address 0, stalling the CPU and muxing its memory port while loading.
module loader_fsm #(
  parameter int SIZE  = 13,
  parameter int DEPTH = 8192
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [SIZE:0]   i_len,
  input  logic [7:0]      i_byte,
  input  logic            i_byte_valid,
  output logic            o_byte_ready,
  input  logic            i_cpu_we,
  input  logic [SIZE-1:0] i_cpu_addr,
  input  logic [15:0]     i_cpu_data,
  output logic            o_ram_we,
  output logic [SIZE-1:0] o_ram_addr,
  output logic [15:0]     o_ram_data,
  output logic            o_busy,
  output logic            o_cpu_hold,
  output logic            o_done
);

  typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_WRITE, S_DONE} state_t;

  localparam logic [SIZE:0] LP_DEPTH = (SIZE+1)'(DEPTH);
  localparam logic [SIZE:0] LP_ONE   = (SIZE+1)'(1);

  state_t            r_state, w_next;
  logic [SIZE-1:0]   r_ptr;
  logic [SIZE:0]     r_len;
  logic [7:0]        r_lo, r_hi;

  logic              w_xfer, w_last;
  logic [SIZE:0]     w_len_sat;

  assign w_xfer    = i_byte_valid & o_byte_ready;
  assign w_len_sat = (i_len > LP_DEPTH) ? LP_DEPTH : i_len;
  // r_len >= 1 whenever a word is being written, so len-1 cannot underflow here
  assign w_last    = ({1'b0, r_ptr} == (r_len - LP_ONE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = (i_len == '0) ? S_DONE : S_LO;
      S_LO:    if (w_xfer) w_next = S_HI;
      S_HI:    if (w_xfer) w_next = S_WRITE;
      S_WRITE: w_next = w_last ? S_DONE : S_LO;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
      r_len <= '0;
      r_lo  <= '0;
      r_hi  <= '0;
    end else begin
      if (r_state == S_IDLE && i_start && i_len != '0) begin
        r_len <= w_len_sat;
        r_ptr <= '0;
      end
      if (r_state == S_LO && w_xfer) r_lo <= i_byte;
      if (r_state == S_HI && w_xfer) r_hi <= i_byte;
      // pointer stops at len-1, so it never wraps even for a full-depth load
      if (r_state == S_WRITE && !w_last) r_ptr <= r_ptr + 1'b1;
    end
  end

  always_comb begin
    o_ram_we     = 1'b0;
    o_ram_addr   = r_ptr;
    o_ram_data   = {r_hi, r_lo};
    o_busy       = 1'b0;
    o_cpu_hold   = 1'b0;
    o_byte_ready = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_ram_we   = i_cpu_we;
        o_ram_addr = i_cpu_addr;
        o_ram_data = i_cpu_data;
      end
      S_LO, S_HI: begin
        o_busy       = 1'b1;
        o_cpu_hold   = 1'b1;
        o_byte_ready = 1'b1;
      end
      S_WRITE: begin
        o_busy     = 1'b1;
        o_cpu_hold = 1'b1;
        o_ram_we   = 1'b1;
      end
      S_DONE: begin
        o_done     = 1'b1;
        o_cpu_hold = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_loader_fsm.sv
// Directed bench for loader_fsm with a behavioural RAM and write/done counters.
module tb_loader_fsm;
  localparam int SIZE  = 4;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            i_start = 1'b0;
  logic [SIZE:0]   i_len = '0;
  logic [7:0]      i_byte = '0;
  logic            i_byte_valid = 1'b0;
  logic            o_byte_ready;
  logic            i_cpu_we = 1'b0;
  logic [SIZE-1:0] i_cpu_addr = '0;
  logic [15:0]     i_cpu_data = '0;
  logic            o_ram_we;
  logic [SIZE-1:0] o_ram_addr;
  logic [15:0]     o_ram_data;
  logic            o_busy, o_cpu_hold, o_done;

  int vecs = 0;
  int errs = 0;

  logic [15:0]     mem [DEPTH] = '{default: 16'h0000};
  int              we_cnt = 0;
  int              done_cnt = 0;
  logic [SIZE-1:0] last_addr = '0;

  loader_fsm #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_len(i_len),
    .i_byte(i_byte), .i_byte_valid(i_byte_valid), .o_byte_ready(o_byte_ready),
    .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr), .i_cpu_data(i_cpu_data),
    .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr), .o_ram_data(o_ram_data),
    .o_busy(o_busy), .o_cpu_hold(o_cpu_hold), .o_done(o_done)
  );

  always #5 clk = ~clk;

  // RAM model and event counters, sampled at the active edge
  always @(posedge clk) begin
    if (o_ram_we) begin
      mem[o_ram_addr] <= o_ram_data;
      we_cnt          <= we_cnt + 1;
      last_addr       <= o_ram_addr;
    end
    if (o_done) done_cnt <= done_cnt + 1;
  end

  // Called at a negedge; returns at the negedge right after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    int n;
    i_byte = b; i_byte_valid = 1'b1; n = 0;
    while (!o_byte_ready && n < 20) begin @(negedge clk); n++; end
    vecs++;
    if (!o_byte_ready) begin
      errs++; $display("FAIL byte_ready_timeout: ready=%0b required 1", o_byte_ready);
    end
    @(negedge clk);
    i_byte_valid = 1'b0;
  endtask

  task automatic start_load(input logic [SIZE:0] len);
    @(negedge clk);
    i_start = 1'b1; i_len = len;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic test_reset;
    i_cpu_addr = 4'h3; i_cpu_data = 16'h1111; i_byte_valid = 1'b1;
    @(negedge clk);
    vecs++; if ({o_busy, o_cpu_hold, o_byte_ready, o_done} !== 4'b0000) begin
      errs++; $display("FAIL reset_flags: got %b required 0000", {o_busy, o_cpu_hold, o_byte_ready, o_done}); end
    vecs++; if (o_ram_addr !== 4'h3 || o_ram_data !== 16'h1111 || o_ram_we !== 1'b0) begin
      errs++; $display("FAIL reset_passthru: got we=%b a=%h d=%h required 0/3/1111", o_ram_we, o_ram_addr, o_ram_data); end
    rst = 1'b1; i_byte_valid = 1'b0;
    @(negedge clk);
    vecs++; if (o_busy !== 1'b0 || o_byte_ready !== 1'b0) begin
      errs++; $display("FAIL idle_after_reset: busy=%b ready=%b required 0/0", o_busy, o_byte_ready); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [7];
    int w0, d0;
    bytes = '{8'h34, 8'h12, 8'h00, 8'h78, 8'h56, 8'h00, 8'h00};
    w0 = we_cnt; d0 = done_cnt;
    start_load(5'd2);
    for (int k = 0; k < 7; k++) begin
      i_byte = bytes[k]; i_byte_valid = (k < 5);
      vecs++; if (o_done !== (k == 6)) begin
        errs++; $display("FAIL b2b_done cyc%0d: got %b required %b", k, o_done, (k == 6)); end
      vecs++; if (o_ram_we !== (k == 2 || k == 5)) begin
        errs++; $display("FAIL b2b_we cyc%0d: got %b required %b", k, o_ram_we, (k == 2 || k == 5)); end
      if (k == 2) begin
        vecs++; if (o_ram_addr !== 4'd0 || o_ram_data !== 16'h1234) begin
          errs++; $display("FAIL b2b_word0: got %h/%h required 0/1234", o_ram_addr, o_ram_data); end
      end
      if (k == 5) begin
        vecs++; if (o_ram_addr !== 4'd1 || o_ram_data !== 16'h5678) begin
          errs++; $display("FAIL b2b_word1: got %h/%h required 1/5678", o_ram_addr, o_ram_data); end
      end
      if (k == 6) begin
        vecs++; if (o_busy !== 1'b0 || o_cpu_hold !== 1'b1) begin
          errs++; $display("FAIL done_flags: busy=%b hold=%b required 0/1", o_busy, o_cpu_hold); end
      end
      @(negedge clk);
    end
    i_byte_valid = 1'b0;
    vecs++; if (mem[0] !== 16'h1234 || mem[1] !== 16'h5678) begin
      errs++; $display("FAIL b2b_ram: got %h %h required 1234 5678", mem[0], mem[1]); end
    vecs++; if (we_cnt - w0 !== 2 || done_cnt - d0 !== 1) begin
      errs++; $display("FAIL b2b_counts: we=%0d done=%0d required 2/1", we_cnt - w0, done_cnt - d0); end
  endtask

  task automatic test_gap;
    int w0;
    w0 = we_cnt;
    start_load(5'd1);
    send_byte(8'hCD);
    for (int k = 0; k < 5; k++) begin
      vecs++; if (o_byte_ready !== 1'b1 || o_ram_we !== 1'b0) begin
        errs++; $display("FAIL gap_ready cyc%0d: ready=%b we=%b required 1/0", k, o_byte_ready, o_ram_we); end
      @(negedge clk);
    end
    send_byte(8'hAB);
    vecs++; if (o_ram_we !== 1'b1 || o_ram_data !== 16'hABCD || o_ram_addr !== 4'd0) begin
      errs++; $display("FAIL gap_write: got %b/%h/%h required 1/0/abcd", o_ram_we, o_ram_addr, o_ram_data); end
    @(negedge clk); @(negedge clk);
    vecs++; if (we_cnt - w0 !== 1 || mem[0] !== 16'hABCD) begin
      errs++; $display("FAIL gap_ram: writes=%0d mem0=%h required 1/abcd", we_cnt - w0, mem[0]); end
  endtask

  task automatic test_zero_len;
    int w0;
    w0 = we_cnt;
    start_load(5'd0);
    vecs++; if (o_done !== 1'b1 || o_busy !== 1'b0 || o_ram_we !== 1'b0) begin
      errs++; $display("FAIL zero_done: done=%b busy=%b we=%b required 1/0/0", o_done, o_busy, o_ram_we); end
    @(negedge clk);
    vecs++; if (o_done !== 1'b0 || o_busy !== 1'b0 || o_cpu_hold !== 1'b0) begin
      errs++; $display("FAIL zero_idle: done=%b busy=%b hold=%b required 0/0/0", o_done, o_busy, o_cpu_hold); end
    vecs++; if (we_cnt !== w0) begin
      errs++; $display("FAIL zero_writes: got %0d required 0", we_cnt - w0); end
  endtask

  task automatic test_cpu_port;
    start_load(5'd1);
    i_cpu_we = 1'b1; i_cpu_addr = 4'd5; i_cpu_data = 16'hBEEF;
    send_byte(8'h42);
    send_byte(8'h00);
    i_cpu_we = 1'b0;
    @(negedge clk); @(negedge clk);
    vecs++; if (mem[5] !== 16'h0000 || mem[0] !== 16'h0042) begin
      errs++; $display("FAIL cpu_blocked: mem5=%h mem0=%h required 0000/0042", mem[5], mem[0]); end
    i_cpu_we = 1'b1;
    #1;
    vecs++; if (o_ram_we !== 1'b1 || o_ram_addr !== 4'd5 || o_ram_data !== 16'hBEEF) begin
      errs++; $display("FAIL cpu_passthru: got %b/%h/%h required 1/5/beef", o_ram_we, o_ram_addr, o_ram_data); end
    @(negedge clk);
    i_cpu_we = 1'b0;
    vecs++; if (mem[5] !== 16'hBEEF) begin
      errs++; $display("FAIL cpu_idle_write: mem5=%h required beef", mem[5]); end
  endtask

  task automatic test_reset_midload;
    int w0;
    w0 = we_cnt;
    start_load(5'd1);
    send_byte(8'h11);
    i_cpu_addr = 4'h9; i_cpu_data = 16'h7777;
    #2 rst = 1'b0;
    #1;
    vecs++; if ({o_busy, o_cpu_hold, o_byte_ready, o_ram_we} !== 4'b0000) begin
      errs++; $display("FAIL async_abort: got %b required 0000", {o_busy, o_cpu_hold, o_byte_ready, o_ram_we}); end
    vecs++; if (o_ram_addr !== 4'h9 || o_ram_data !== 16'h7777) begin
      errs++; $display("FAIL abort_passthru: got %h/%h required 9/7777", o_ram_addr, o_ram_data); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    vecs++; if (o_busy !== 1'b0 || we_cnt !== w0) begin
      errs++; $display("FAIL abort_idle: busy=%b writes=%0d required 0/0", o_busy, we_cnt - w0); end
    start_load(5'd1);
    send_byte(8'h22);
    send_byte(8'h33);
    @(negedge clk); @(negedge clk);
    vecs++; if (mem[0] !== 16'h3322 || we_cnt - w0 !== 1) begin
      errs++; $display("FAIL reload: mem0=%h writes=%0d required 3322/1", mem[0], we_cnt - w0); end
  endtask

  // full-depth load; stray i_start with a short length mid-load must not shorten it
  task automatic test_full(input logic [SIZE:0] len, input logic [15:0] base);
    int w0, d0, bad;
    w0 = we_cnt; d0 = done_cnt; bad = 0;
    start_load(len);
    for (int i = 0; i < DEPTH; i++) begin
      logic [15:0] w;
      w = base + 16'(i);
      if (i == 3) begin i_start = 1'b1; i_len = 5'd1; end
      send_byte(w[7:0]);
      i_start = 1'b0;
      send_byte(w[15:8]);
    end
    for (int k = 0; k < 4; k++) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== base + 16'(i)) bad++;
    vecs++; if (bad != 0) begin
      errs++; $display("FAIL full_ram len=%0d: %0d words wrong", len, bad); end
    vecs++; if (we_cnt - w0 !== DEPTH || done_cnt - d0 !== 1) begin
      errs++; $display("FAIL full_counts len=%0d: we=%0d done=%0d required %0d/1", len, we_cnt - w0, done_cnt - d0, DEPTH); end
    vecs++; if (last_addr !== 4'(DEPTH-1) || o_busy !== 1'b0) begin
      errs++; $display("FAIL full_last len=%0d: last=%0d busy=%b required %0d/0", len, last_addr, o_busy, DEPTH-1); end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_gap;
    test_zero_len;
    test_cpu_port;
    test_reset_midload;
    test_full(5'(DEPTH), 16'hA000);
    test_full(5'(DEPTH + 5), 16'hB000);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
